dma_bus_arbiter: RTL and testbench
==================================

// Module: dma_bus_arbiter
// PURPOSE
//  Multi-channel successor to the single-DMA bus-grant handler. Arbitrates the
//  data-memory bus between the CPU and N_CH DMA controllers. Sits between the
//  CPU datapath (d-memory port status) and the DMA channels (BR/BG handshakes).
//  Grants never interrupt an in-flight CPU d-memory access. All logic is
//  synchronous; the BG release path is clocked, not edge-triggered on BR.
// PARAMETERS
//  N_CH       2   number of DMA channels, 1..8
//  WORD_SIZE  16  CPU word width; d_data is 4*WORD_SIZE bits
//  MAX_HOLD   64  max grant length in cycles; used only with DMA_HOLD_WATCHDOG_EN
// PORTS
//  clk           in   1            system clock, rising edge
//  reset         in   1            synchronous, active-high reset
//  BR            in   N_CH         per-channel bus request, level
//  BG            out  N_CH         per-channel bus grant, one-hot or zero
//  dma_start_int in   N_CH         per-channel start interrupt, level
//  dma_end_int   in   N_CH         per-channel end interrupt, level
//  cmd           out  N_CH         registered copy of dma_start_int
//  dma_done      out  N_CH         1-cycle pulse on rising edge of dma_end_int
//  d_readM       in   1            CPU d-memory read request
//  d_writeM      in   1            CPU d-memory write request
//  d_data        in   4*WORD_SIZE  d-memory read line
//  doneWrite_d   in   1            d-memory write complete
//  bus_owner     out  3            index of granted channel; 0 when none granted
//  bus_busy      out  1            |BG
//  hold_timeout  out  N_CH         1-cycle watchdog pulse; 0 without macro
// BEHAVIOUR
//  - Reset: BG=0, cmd=0, dma_done=0, bus_owner=0, bus_busy=0, hold_timeout=0.
//    State=IDLE, rr_ptr=N_CH-1 (channel 0 wins first). Reset mid-grant drops BG
//    at that same edge.
//  - mem_busy = (d_readM && d_data[4*WORD_SIZE-1 -: 4]==`OPCODE_NOP)
//               || (d_writeM && !doneWrite_d).
//  - Winner = first asserted BR (not masked) searching from rr_ptr+1 mod N_CH
//    upward. It is latched as win_idx.
//  - FSM:
//    - IDLE: any eligible BR -> latch winner.
//      - !mem_busy -> GRANTED; BG[win] is 1 the next cycle (latency 1 from BR).
//      - else -> WAIT_MEM.
//    - WAIT_MEM: BR[win] dropped -> IDLE, no grant. !mem_busy -> GRANTED.
//      Winner is not re-arbitrated while waiting.
//    - GRANTED: BG[win]=1 and rr_ptr<=win.
//      - BR[win]=0 -> BG[win]=0 the next cycle, go to RELEASE.
//      - Other channels' BR rising here wait; they are never preempted.
//    - RELEASE: one dead cycle, all BG=0, CPU owns the bus. Then IDLE.
//      Back-to-back grants are therefore separated by at least 1 cycle.
//  - BR dropping and another BR rising in the same cycle: the drop is handled
//    first (RELEASE); the new request is arbitrated in IDLE.
//  - cmd[i] <= dma_start_int[i] every cycle (1-cycle latency, level, no FSM gating).
//  - dma_done[i] <= dma_end_int[i] & ~end_q[i], where end_q is the delayed
//    dma_end_int. Output is a single pulse.
//  - bus_owner and bus_busy are registered; they are consistent with BG in the
//    same cycle.
// CONFIGURATION
//  - DMA_HOLD_WATCHDOG_EN defined:
//    - An 8..16-bit hold counter clears on entry to GRANTED and increments each
//      GRANTED cycle.
//    - When the counter reaches MAX_HOLD-1 with BR[win] still high: BG drops at
//      the next edge, hold_timeout[win] pulses 1 cycle, the FSM goes to RELEASE,
//      and win is masked from arbitration until its BR goes low.
//  - DMA_HOLD_WATCHDOG_EN undefined: no counter or mask; a grant is held
//    indefinitely; hold_timeout is tied to 0; MAX_HOLD is ignored.
// TESTING
//  - Idle memory, BR=2'b01 at cycle 0 -> BG=2'b01 at cycle 1. BR drops at
//    cycle 5 -> BG=0 at cycle 6, bus_busy=0.
//  - d_writeM=1, doneWrite_d=0 for 4 cycles, BR[0]=1 -> BG stays 0 until the
//    cycle after doneWrite_d=1; then BG=2'b01.
//  - BR=2'b11 held, each grant released after 3 cycles -> grant order 0,1,0,1
//    with >=1 all-zero BG cycle between grants.
//  - dma_start_int[1] 0->1 -> cmd[1]=1 one cycle later. dma_end_int[0] held
//    high 5 cycles -> dma_done[0] pulses exactly once.
//  - reset=1 while BG=2'b10 -> BG=0, bus_owner=0 at that edge. BR=2'b11 after
//    reset -> channel 0 granted first.
//  - With DMA_HOLD_WATCHDOG_EN, MAX_HOLD=8, BR[0] stuck high -> BG[0] drops
//    after 8 grant cycles, hold_timeout[0] pulses; BR[1] is then granted;
//    ch0 is not regranted until BR[0] toggles.

Source files
------------

// File: rtl/dma_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_arbiter_if
// Purpose  : DMA request/grant, interrupt and CPU d-memory status bundle
//            shared by dma_bus_arbiter and the agents around it.
// Revision : 1.0  initial release
// ============================================================================
interface dma_bus_arbiter_if #(
  parameter int N_CH      = 2,
  parameter int WORD_SIZE = 16
);
  logic [N_CH-1:0]        i_br;
  logic [N_CH-1:0]        o_bg;
  logic [N_CH-1:0]        i_dma_start_int;
  logic [N_CH-1:0]        i_dma_end_int;
  logic [N_CH-1:0]        o_cmd;
  logic [N_CH-1:0]        o_dma_done;
  logic                   i_d_readM;
  logic                   i_d_writeM;
  logic [4*WORD_SIZE-1:0] i_d_data;
  logic                   i_doneWrite_d;
  logic [2:0]             o_bus_owner;
  logic                   o_bus_busy;
  logic [N_CH-1:0]        o_hold_timeout;

  // Arbiter side
  modport slave (
    input  i_br, i_dma_start_int, i_dma_end_int,
    input  i_d_readM, i_d_writeM, i_d_data, i_doneWrite_d,
    output o_bg, o_cmd, o_dma_done, o_bus_owner, o_bus_busy, o_hold_timeout
  );

  // DMA channels / CPU side
  modport master (
    output i_br, i_dma_start_int, i_dma_end_int,
    output i_d_readM, i_d_writeM, i_d_data, i_doneWrite_d,
    input  o_bg, o_cmd, o_dma_done, o_bus_owner, o_bus_busy, o_hold_timeout
  );
endinterface
`default_nettype wire

// File: rtl/dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_bus_arbiter
// Purpose  : Round-robin data-memory bus arbiter between the CPU and N_CH DMA
//            channels; optional grant watchdog under DMA_HOLD_WATCHDOG_EN.
// Revision : 1.0  initial release
// ============================================================================
`ifndef OPCODE_NOP
`define OPCODE_NOP 4'hF
`endif

module dma_bus_arbiter #(
  parameter int N_CH      = 2,
  parameter int WORD_SIZE = 16,
  parameter int MAX_HOLD  = 64
) (
  input  logic             clk,
  input  logic             reset,
  dma_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_GRANTED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_win, w_win_nxt;
  logic [2:0]      r_rr_ptr, w_rr_nxt;
  logic [2:0]      r_owner, w_owner_nxt;
  logic [2:0]      w_winner, w_sel;
  logic [N_CH-1:0] r_bg, w_bg_nxt;
  logic [N_CH-1:0] w_elig, w_sel_onehot;
  logic [N_CH-1:0] r_cmd, r_done, r_end_q;
  logic            r_busy;
  logic            w_any, w_win_req, w_mem_busy;
  logic            w_unused_data;

  if ((N_CH < 1) || (N_CH > 8) || (MAX_HOLD < 2)) begin : g_bad_cfg
    $error("dma_bus_arbiter: unsupported parameter set");
  end

  // A read whose returned line still carries a NOP opcode has not completed yet
  assign w_mem_busy = (bus.i_d_readM && (bus.i_d_data[4*WORD_SIZE-1 -: 4] == `OPCODE_NOP))
                   || (bus.i_d_writeM && !bus.i_doneWrite_d);
  assign w_unused_data = ^bus.i_d_data[4*WORD_SIZE-5:0];

`ifdef DMA_HOLD_WATCHDOG_EN
  localparam int HOLD_W = ($clog2(MAX_HOLD) > 8) ? 16 : 8;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [N_CH-1:0]   r_mask, r_timeout, w_timeout_nxt;
  logic              w_hold_expired;

  assign w_elig         = bus.i_br & ~r_mask;
  assign w_hold_expired = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  assign w_elig = bus.i_br;
`endif

  always_comb begin
    w_any    = 1'b0;
    w_winner = 3'd0;
    for (int k = 1; k <= N_CH; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!w_any && (i == (int'(r_rr_ptr) + k) % N_CH) && w_elig[i]) begin
          w_any    = 1'b1;
          w_winner = 3'(i);
        end
      end
    end
  end

  // Only IDLE picks a fresh winner; every other state works on the latched one
  assign w_sel = (r_state == S_IDLE) ? w_winner : r_win;

  always_comb begin
    w_sel_onehot = '0;
    w_win_req    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_sel_onehot[i] = (3'(i) == w_sel);
      if (3'(i) == r_win) begin
        w_win_req = bus.i_br[i];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_rr_nxt    = r_rr_ptr;
    w_bg_nxt    = r_bg;
`ifdef DMA_HOLD_WATCHDOG_EN
    w_timeout_nxt = '0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_win_nxt = w_winner;
          if (!w_mem_busy) begin
            w_state_nxt = S_GRANTED;
            w_bg_nxt    = w_sel_onehot;
            w_rr_nxt    = w_winner;
          end else begin
            w_state_nxt = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        if (!w_win_req) begin
          w_state_nxt = S_IDLE;
        end else if (!w_mem_busy) begin
          w_state_nxt = S_GRANTED;
          w_bg_nxt    = w_sel_onehot;
          w_rr_nxt    = r_win;
        end
      end
      S_GRANTED: begin
        if (!w_win_req) begin
          w_state_nxt = S_RELEASE;
          w_bg_nxt    = '0;
        end
`ifdef DMA_HOLD_WATCHDOG_EN
        else if (w_hold_expired) begin
          w_state_nxt   = S_RELEASE;
          w_bg_nxt      = '0;
          w_timeout_nxt = w_sel_onehot;
        end
`endif
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_bg_nxt    = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bg_nxt    = '0;
      end
    endcase
    w_owner_nxt = (|w_bg_nxt) ? w_sel : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_win    <= 3'd0;
      r_rr_ptr <= 3'(N_CH - 1);
      r_bg     <= '0;
      r_owner  <= 3'd0;
      r_busy   <= 1'b0;
      r_cmd    <= '0;
      r_done   <= '0;
      r_end_q  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_win    <= w_win_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_bg     <= w_bg_nxt;
      r_owner  <= w_owner_nxt;
      r_busy   <= |w_bg_nxt;
      r_cmd    <= bus.i_dma_start_int;
      r_done   <= bus.i_dma_end_int & ~r_end_q;
      r_end_q  <= bus.i_dma_end_int;
    end
  end

`ifdef DMA_HOLD_WATCHDOG_EN
  // A timed-out channel stays masked until it lowers its request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
      r_mask     <= '0;
      r_timeout  <= '0;
    end else begin
      r_timeout  <= w_timeout_nxt;
      r_mask     <= (r_mask & bus.i_br) | w_timeout_nxt;
      r_hold_cnt <= (r_state == S_GRANTED) ? r_hold_cnt + 1'b1 : '0;
    end
  end

  assign bus.o_hold_timeout = r_timeout;
`else
  assign bus.o_hold_timeout = '0;
`endif

  assign bus.o_bg        = r_bg;
  assign bus.o_cmd       = r_cmd;
  assign bus.o_dma_done  = r_done;
  assign bus.o_bus_owner = r_owner;
  assign bus.o_bus_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_bus_arbiter
// Purpose  : Directed and randomized bench for dma_bus_arbiter against a
//            request-level reference model (default build).
// Revision : 1.0  initial release
// ============================================================================
module tb_dma_bus_arbiter;

  localparam int         N_CH      = 2;
  localparam int         WORD_SIZE = 16;
  localparam logic [3:0] OP_NOP    = 4'hF;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.N_CH(N_CH), .WORD_SIZE(WORD_SIZE)) bus ();

  dma_bus_arbiter #(
    .N_CH      (N_CH),
    .WORD_SIZE (WORD_SIZE),
    .MAX_HOLD  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: owner/pending channel, dead-cycle count, last served
  int              m_owner = -1;
  int              m_pend  = -1;
  int              m_gap   = 0;
  int              m_last  = N_CH - 1;
  logic [N_CH-1:0] m_cmd   = '0;
  logic [N_CH-1:0] m_done  = '0;
  logic [N_CH-1:0] m_endq  = '0;

  logic [N_CH-1:0] st_start = '0;
  logic [N_CH-1:0] st_end   = '0;
  logic            st_rd    = 1'b0;
  logic            st_wr    = 1'b0;
  logic            st_wdone = 1'b0;
  logic [3:0]      st_op    = 4'h0;

  logic [N_CH-1:0] obs_bg, obs_cmd, obs_done;
  logic [2:0]      obs_owner;
  logic            obs_busy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_pend  = -1;
    m_gap   = 0;
    m_last  = N_CH - 1;
    m_cmd   = '0;
    m_done  = '0;
    m_endq  = '0;
  endtask

  task automatic apply(input logic rst, input logic [N_CH-1:0] br);
    logic mbusy;
    bit   found;
    int   c;
    reset               = rst;
    bus.i_br            = br;
    bus.i_dma_start_int = st_start;
    bus.i_dma_end_int   = st_end;
    bus.i_d_readM       = st_rd;
    bus.i_d_writeM      = st_wr;
    bus.i_doneWrite_d   = st_wdone;
    bus.i_d_data        = {st_op, 28'h0, 32'($urandom)};
    mbusy = (st_rd && (st_op == OP_NOP)) || (st_wr && !st_wdone);
    if (rst) begin
      model_reset();
    end else begin
      m_cmd  = st_start;
      m_done = st_end & ~m_endq;
      m_endq = st_end;
      if (m_owner >= 0) begin
        if (!br[m_owner]) begin
          m_owner = -1;
          m_gap   = 1;
        end
      end else if (m_gap > 0) begin
        m_gap = 0;
      end else if (m_pend >= 0) begin
        if (!br[m_pend]) m_pend = -1;
        else if (!mbusy) begin
          m_owner = m_pend;
          m_last  = m_pend;
          m_pend  = -1;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
          c = (m_last + k) % N_CH;
          if (!found && br[c]) begin
            found = 1'b1;
            if (!mbusy) begin
              m_owner = c;
              m_last  = c;
            end else begin
              m_pend = c;
            end
          end
        end
      end
    end
  endtask

  task automatic observe();
    logic [N_CH-1:0] e_bg;
    @(negedge clk);
    obs_bg    = bus.o_bg;
    obs_cmd   = bus.o_cmd;
    obs_done  = bus.o_dma_done;
    obs_owner = bus.o_bus_owner;
    obs_busy  = bus.o_bus_busy;
    e_bg = '0;
    if (m_owner >= 0) e_bg[m_owner] = 1'b1;
    check_eq("bg",    64'(obs_bg),    64'(e_bg));
    check_eq("owner", 64'(obs_owner), 64'((m_owner >= 0) ? m_owner : 0));
    check_eq("busy",  64'(obs_busy),  64'(m_owner >= 0));
    check_eq("cmd",   64'(obs_cmd),   64'(m_cmd));
    check_eq("done",  64'(obs_done),  64'(m_done));
    check_eq("hold_to", 64'(bus.o_hold_timeout), 64'(0));
  endtask

  task automatic tick(input logic rst, input logic [N_CH-1:0] br);
    apply(rst, br);
    observe();
  endtask

  initial begin
    logic [N_CH-1:0] br_v;
    int hold, gap, n_grants, pulses;
    int order [4];

    apply(1'b1, '0);
    observe();
    tick(1'b1, '0);

    // Single request on an idle memory port
    tick(1'b0, 2'b01);
    check_eq("s1_grant", 64'(obs_bg), 64'(2'b01));
    repeat (4) tick(1'b0, 2'b01);
    tick(1'b0, 2'b00);
    check_eq("s1_release_bg", 64'(obs_bg), 64'(0));
    check_eq("s1_release_busy", 64'(obs_busy), 64'(0));
    repeat (3) tick(1'b0, 2'b00);

    // Grant deferred behind an outstanding CPU write
    st_wr    = 1'b1;
    st_wdone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 2'b01);
      check_eq("s2_wait", 64'(obs_bg), 64'(0));
    end
    st_wdone = 1'b1;
    tick(1'b0, 2'b01);
    check_eq("s2_grant", 64'(obs_bg), 64'(2'b01));
    st_wr    = 1'b0;
    st_wdone = 1'b0;
    repeat (4) tick(1'b0, 2'b00);

    // Round-robin with both channels requesting, 3-cycle grants
    tick(1'b1, 2'b00);
    tick(1'b0, 2'b00);
    br_v     = 2'b11;
    hold     = 0;
    gap      = 0;
    n_grants = 0;
    for (int cyc = 0; cyc < 60 && n_grants < 4; cyc++) begin
      tick(1'b0, br_v);
      if (obs_bg != '0) begin
        if (hold == 0) begin
          order[n_grants] = obs_bg[1] ? 1 : 0;
          if (n_grants > 0) check_eq("s3_gap", 64'(gap >= 1), 64'(1));
          n_grants++;
        end
        hold++;
        gap = 0;
      end else begin
        gap++;
        hold = 0;
      end
      br_v = (hold == 3) ? (2'b11 & ~obs_bg) : 2'b11;
    end
    check_eq("s3_count", 64'(n_grants), 64'(4));
    check_eq("s3_order0", 64'(order[0]), 64'(0));
    check_eq("s3_order1", 64'(order[1]), 64'(1));
    check_eq("s3_order2", 64'(order[2]), 64'(0));
    check_eq("s3_order3", 64'(order[3]), 64'(1));

    // Reset while channel 1 holds the bus, then both request
    check_eq("s5_pre_bg", 64'(obs_bg), 64'(2'b10));
    tick(1'b1, 2'b11);
    check_eq("s5_rst_bg", 64'(obs_bg), 64'(0));
    check_eq("s5_rst_owner", 64'(obs_owner), 64'(0));
    tick(1'b0, 2'b11);
    check_eq("s5_first", 64'(obs_bg), 64'(2'b01));
    repeat (3) tick(1'b0, 2'b00);

    // Interrupt forwarding
    st_start = 2'b10;
    tick(1'b0, 2'b00);
    check_eq("s4_cmd1", 64'(obs_cmd[1]), 64'(1));
    st_start = 2'b00;
    tick(1'b0, 2'b00);
    st_end = 2'b01;
    pulses = 0;
    repeat (5) begin
      tick(1'b0, 2'b00);
      pulses += int'(obs_done[0]);
    end
    st_end = 2'b00;
    repeat (2) begin
      tick(1'b0, 2'b00);
      pulses += int'(obs_done[0]);
    end
    check_eq("s4_done_pulses", 64'(pulses), 64'(1));

    // Randomized traffic
    br_v = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 5) == 0) br_v[ch] = ~br_v[ch];
        if ($urandom_range(0, 7) == 0) st_start[ch] = ~st_start[ch];
        if ($urandom_range(0, 5) == 0) st_end[ch] = ~st_end[ch];
      end
      st_rd    = ($urandom_range(0, 2) == 0);
      st_op    = ($urandom_range(0, 1) == 0) ? OP_NOP : 4'($urandom_range(0, 14));
      st_wr    = ($urandom_range(0, 2) == 0);
      st_wdone = ($urandom_range(0, 1) == 0);
      tick(($urandom_range(0, 99) == 0), br_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
